// File: rtl/bcd_timer.sv
// bcd_timer: BCD minutes:seconds timer that counts up or down between two limits.
// It has a run/pause/done state machine, a prescaler with selectable speed levels,
// and a saturating +/-1 minute adjust.
//
// Ports:
//   clk_in      clock, rising edge
//   RESET_N     asynchronous active-low reset
//   CLEAR       synchronous reload: Q=preset, state=idle, prescaler=0
//   START       level, run permitted
//   REVERSE     0 = count up toward LIMIT_HI, 1 = count down toward LIMIT_LO
//   SPEED_UP    pulse, raise the speed level (saturating)
//   SPEED_DOWN  pulse, lower the speed level (saturating)
//   ADD         pulse, +1 minute (saturating at LIMIT_HI)
//   SUBTRACT    pulse, -1 minute (saturating at LIMIT_LO)
//   Q           packed BCD time {minute digits, seconds tens, seconds units}
//   SPEED       current speed level
//   RUNNING     high while running
//   DONE        high once the target has been reached
//   TICK        one-cycle pulse marking a count-step update of Q
module bcd_timer #(
  parameter int unsigned MIN_DIGITS = 2,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned SPEED_LEVELS = 4,
  parameter logic [4*MIN_DIGITS+7:0] LIMIT_LO = '0,
  parameter logic [4*MIN_DIGITS+7:0] LIMIT_HI = {{MIN_DIGITS{4'h9}}, 4'h5, 4'h9},
  localparam int unsigned W = 4*MIN_DIGITS+8,
  localparam int unsigned SpeedW = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1
) (
  input  logic              clk_in,
  input  logic              RESET_N,
  input  logic              CLEAR,
  input  logic              START,
  input  logic              REVERSE,
  input  logic              SPEED_UP,
  input  logic              SPEED_DOWN,
  input  logic              ADD,
  input  logic              SUBTRACT,
  output logic [W-1:0]      Q,
  output logic [SpeedW-1:0] SPEED,
  output logic              RUNNING,
  output logic              DONE,
  output logic              TICK
);

  localparam int unsigned NDig = MIN_DIGITS + 2;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SpeedW-1:0] SpeedMax = SpeedW'(SPEED_LEVELS - 1);
  localparam logic [4*MIN_DIGITS-1:0] MinAllNine = {MIN_DIGITS{4'h9}};

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      time_q, time_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [SpeedW-1:0] speed_q, speed_d;
  logic              tick_q, tick_d;
  logic              running_q, done_q;

  // Increment digits from index 'first' upward; digit 1 (seconds tens) wraps at 5.
  function automatic logic [W-1:0] bcd_up(input logic [W-1:0] v, input int unsigned first);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    logic [3:0]   dmax;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < NDig; i++) begin
      if (i >= first && c) begin
        d    = v[4*i +: 4];
        dmax = (i == 1) ? 4'd5 : 4'd9;
        if (d >= dmax) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Decrement digits from index 'first' upward with BCD borrow.
  function automatic logic [W-1:0] bcd_dn(input logic [W-1:0] v, input int unsigned first);
    logic [W-1:0] r;
    logic         b;
    logic [3:0]   d;
    r = v;
    b = 1'b1;
    for (int unsigned i = 0; i < NDig; i++) begin
      if (i >= first && b) begin
        d = v[4*i +: 4];
        if (d == 4'd0) begin
          r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0]  target, preset;
  logic [W-1:0]  sec_up, sec_dn, min_up, min_dn;
  logic [W-1:0]  add_val, sub_val;
  logic          min_ovf, min_unf;
  logic [PW-1:0] term_cnt;
  logic          spd_inc, spd_dec, speed_chg;
  logic          adjust, counting, terminal, step_en;

  assign target = REVERSE ? LIMIT_LO : LIMIT_HI;
  assign preset = REVERSE ? LIMIT_HI : LIMIT_LO;

  assign sec_up = bcd_up(time_q, 0);
  assign sec_dn = bcd_dn(time_q, 0);
  assign min_up = bcd_up(time_q, 2);
  assign min_dn = bcd_dn(time_q, 2);

  // Minute digits wrapping past all-nines or below zero means out of range.
  assign min_ovf = (time_q[W-1:8] >= MinAllNine);
  assign min_unf = (time_q[W-1:8] == '0);
  assign add_val = (min_ovf || (min_up > LIMIT_HI)) ? LIMIT_HI : min_up;
  assign sub_val = (min_unf || (min_dn < LIMIT_LO)) ? LIMIT_LO : min_dn;

  assign spd_inc   = SPEED_UP & ~SPEED_DOWN & (speed_q != SpeedMax);
  assign spd_dec   = SPEED_DOWN & ~SPEED_UP & (speed_q != '0);
  assign speed_chg = spd_inc | spd_dec;

  assign term_cnt = PW'((TICK_DIV >> speed_q) - 32'd1);
  assign adjust   = ADD ^ SUBTRACT;
  // A run at the target only waits for the transition to done; it never steps.
  assign counting = (state_q == StRun) && START && (time_q != target);
  assign terminal = counting && (presc_q >= term_cnt);
  // An adjust or speed change on the terminal count swallows that step.
  assign step_en  = terminal && !adjust && !speed_chg;

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    speed_d = speed_q;
    tick_d  = 1'b0;

    if (spd_inc) begin
      speed_d = speed_q + SpeedW'(1);
    end else if (spd_dec) begin
      speed_d = speed_q - SpeedW'(1);
    end

    if (CLEAR) begin
      time_d  = preset;
      state_d = StIdle;
      presc_d = '0;
    end else begin
      if (adjust) begin
        time_d = ADD ? add_val : sub_val;
      end else if (step_en) begin
        time_d = REVERSE ? sec_dn : sec_up;
        tick_d = 1'b1;
      end

      if ((state_q == StIdle) || speed_chg || terminal) begin
        presc_d = '0;
      end else if (counting) begin
        presc_d = presc_q + PW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (START) state_d = StRun;
        end
        StRun: begin
          if (time_d == target) begin
            state_d = StDone;
          end else if (!START) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (START) state_d = StRun;
        end
        StDone: begin
          if (time_q != target) state_d = StPause;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      time_q    <= LIMIT_LO;
      presc_q   <= '0;
      speed_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      presc_q   <= presc_d;
      speed_q   <= speed_d;
      tick_q    <= tick_d;
      running_q <= (state_d == StRun);
      done_q    <= (state_d == StDone);
    end
  end

  assign Q       = time_q;
  assign SPEED   = speed_q;
  assign RUNNING = running_q;
  assign DONE    = done_q;
  assign TICK    = tick_q;

endmodule
